// File: rtl/cost_rr_arbiter.sv
// cost_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one cost-table lookup port (W/J out,
//   Cost in) among NREQ job-assignment search engines. Each grant is a
//   fixed burst of BURST lookups, which is one full permutation. The
//   returned cost is registered and tagged with a one-hot rsp_valid for the
//   engine that issued the lookup, so it arrives one cycle after the lookup.
//
// Parameters:
//   NREQ   number of requesting engines (2..4; 1 also works)
//   BURST  lookups per grant (1..8, one per worker)
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RST        asynchronous active-low reset
//   req        per-engine request, sampled only at arbitration points
//   req_w      per-engine worker index, slice k = [3k+2:3k]
//   req_j      per-engine job index, sliced the same way as req_w
//   gnt        one-hot grant, held for the whole burst
//   beat       beat index within the current burst
//   W, J       lookup address to the cost memory (0 when no grant)
//   Cost       cost memory data, combinational from W/J
//   rsp_valid  one-hot owner of rsp_cost this cycle
//   rsp_cost   Cost registered from the previous beat cycle
//   burst_cnt  saturating count of completed bursts
//
// Build option:
//   COST_ARB_STATS_EN  when defined, burst_cnt counts completed bursts;
//                      otherwise burst_cnt is tied to 0 and no counter exists.

module cost_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int BURST = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_w,
    input  logic [3*NREQ-1:0]   req_j,
    output logic [NREQ-1:0]     gnt,
    output logic [2:0]          beat,
    output logic [2:0]          W,
    output logic [2:0]          J,
    input  logic [6:0]          Cost,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [6:0]          rsp_cost,
    output logic [15:0]         burst_cnt
);

    localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0]      LAST_BEAT = 3'(BURST - 1);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic          found;
    logic          busy;
    logic          any_req;
    logic          last_beat;
    logic          arb_point;

    assign busy      = (state == BUSY);
    assign any_req   = |req;
    assign last_beat = busy && (beat == LAST_BEAT);
    // Requests are only looked at when idle or when the current burst ends.
    assign arb_point = !busy || last_beat;

    // Round-robin pick: first pass looks above the last winner, second pass
    // wraps around to the low indices including the last winner itself.
    always_comb begin
        pick  = last;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k] && (IW'(k) > last)) begin
                pick  = IW'(k);
                found = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k] && (IW'(k) <= last)) begin
                pick  = IW'(k);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (last_beat && !any_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant, beat and pointer. A new grant restarts beat at 0, which is
    // what makes back-to-back bursts bubble-free.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt  <= '0;
            beat <= '0;
            last <= LAST_IDX;
        end else if (arb_point && any_req) begin
            gnt  <= NREQ'(1) << pick;
            last <= pick;
            beat <= '0;
        end else if (arb_point) begin
            gnt  <= '0;
            beat <= '0;
        end else begin
            beat <= beat + 3'd1;
        end
    end

    // While busy, last always names the granted engine, so it doubles as
    // the lookup mux select.
    always_comb begin
        W = '0;
        J = '0;
        if (busy) begin
            for (int k = 0; k < NREQ; k++) begin
                if (last == IW'(k)) begin
                    W = req_w[3*k +: 3];
                    J = req_j[3*k +: 3];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_valid <= '0;
            rsp_cost  <= '0;
        end else if (busy) begin
            rsp_valid <= gnt;
            rsp_cost  <= Cost;
        end else begin
            rsp_valid <= '0;
            rsp_cost  <= '0;
        end
    end

`ifdef COST_ARB_STATS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            burst_cnt <= '0;
        end else if (last_beat && (burst_cnt != 16'hFFFF)) begin
            burst_cnt <= burst_cnt + 16'd1;
        end
    end
`else
    assign burst_cnt = '0;
`endif

endmodule

// File: tb/tb_cost_rr_arbiter.sv
// tb_cost_rr_arbiter
//
// Purpose:
//   Self-checking bench for cost_rr_arbiter. A transaction-level model
//   decides which engine owns each burst; expected lookup responses are
//   queued when the lookup is issued and a separate monitor matches them
//   against rsp_valid/rsp_cost. Inputs are driven on the falling edge and
//   outputs are sampled shortly after it.

module tb_cost_rr_arbiter;

    localparam int NREQ  = 2;
    localparam int BURST = 8;

    logic                CLK;
    logic                RST;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   req_w;
    logic [3*NREQ-1:0]   req_j;
    logic [NREQ-1:0]     gnt;
    logic [2:0]          beat;
    logic [2:0]          W;
    logic [2:0]          J;
    logic [6:0]          Cost;
    logic [NREQ-1:0]     rsp_valid;
    logic [6:0]          rsp_cost;
    logic [15:0]         burst_cnt;

    cost_rr_arbiter #(
        .NREQ  (NREQ),
        .BURST (BURST)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .req_w     (req_w),
        .req_j     (req_j),
        .gnt       (gnt),
        .beat      (beat),
        .W         (W),
        .J         (J),
        .Cost      (Cost),
        .rsp_valid (rsp_valid),
        .rsp_cost  (rsp_cost),
        .burst_cnt (burst_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cost memory: random contents, combinational read.
    logic [6:0] cost_mem [64];
    assign Cost = cost_mem[{W, J}];

    typedef struct {
        int         due;
        int         owner;
        logic [6:0] cost;
    } rsp_t;

    rsp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model state: who owns the current burst and how far it got.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_beat;
    int m_done;
    int w_drv [NREQ];
    int j_drv [NREQ];

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void modelReset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_beat  = 0;
        m_done  = 0;
    endfunction

    // Advance the model across one rising edge given the request vector
    // that was presented during the cycle.
    function automatic void modelStep(logic [NREQ-1:0] r);
        int order[$];
        bit won;
        if (m_busy && m_beat < BURST - 1) begin
            m_beat++;
            return;
        end
        if (m_busy && m_done < 65535) m_done++;
        for (int i = 0; i < NREQ; i++) order.push_back((m_last + 1 + i) % NREQ);
        won = 0;
        foreach (order[n]) begin
            if (!won && (((r >> order[n]) & 1) != 0)) begin
                m_owner = order[n];
                won     = 1;
            end
        end
        m_busy = won;
        m_beat = 0;
        if (won) m_last = m_owner;
    endfunction

    function automatic logic [31:0] expCnt();
`ifdef COST_ARB_STATS_EN
        return 32'(m_done);
`else
        return 32'd0;
`endif
    endfunction

    // Compare lookup-side outputs with the model and queue the response
    // the current lookup must produce one cycle later.
    task automatic checkOutput();
        logic [31:0] eg, eb, ew, ej;
        eg = m_busy ? (32'd1 << m_owner) : 32'd0;
        eb = m_busy ? 32'(m_beat) : 32'd0;
        ew = m_busy ? 32'(w_drv[m_owner]) : 32'd0;
        ej = m_busy ? 32'(j_drv[m_owner]) : 32'd0;
        check("gnt", 32'(gnt), eg);
        check("beat", 32'(beat), eb);
        check("W", 32'(W), ew);
        check("J", 32'(J), ej);
        check("burst_cnt", 32'(burst_cnt), expCnt());
        if (m_busy) begin
            rsp_t e;
            e.due   = cyc + 1;
            e.owner = m_owner;
            e.cost  = cost_mem[{ew[2:0], ej[2:0]}];
            sb.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r);
        @(negedge CLK);
        req = r;
        for (int k = 0; k < NREQ; k++) begin
            w_drv[k] = int'($urandom_range(0, 7));
            j_drv[k] = int'($urandom_range(0, 7));
            req_w[3*k +: 3] = 3'(w_drv[k]);
            req_j[3*k +: 3] = 3'(j_drv[k]);
        end
        #1;
        checkOutput();
        modelStep(r);
    endtask

    task automatic checkResetZero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_beat"}, 32'(beat), 32'd0);
        check({tag, "_W"}, 32'(W), 32'd0);
        check({tag, "_J"}, 32'(J), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_cost"}, 32'(rsp_cost), 32'd0);
        check({tag, "_burst_cnt"}, 32'(burst_cnt), 32'd0);
    endtask

    // Asynchronous reset pulse landing mid-cycle; any in-flight response
    // is abandoned.
    task automatic doReset();
        @(negedge CLK);
        #3 RST = 1'b0;
        #1;
        checkResetZero("rst");
        sb.delete();
        modelReset();
        @(negedge CLK);
        #1;
        checkResetZero("rst_hold");
        req = '0;
        RST = 1'b1;
    endtask

    // Response monitor, independent of the stimulus sequence.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                check("rsp_missing", 32'(rsp_valid), 32'd1 << sb[0].owner);
                void'(sb.pop_front());
            end
            if (rsp_valid != '0) begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    rsp_t e;
                    e = sb.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << e.owner);
                    check("rsp_cost", 32'(rsp_cost), 32'(e.cost));
                end else begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end
            end else begin
                check("rsp_cost_idle", 32'(rsp_cost), 32'd0);
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    check("rsp_missing", 32'(rsp_valid), 32'd1 << sb[0].owner);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 64; a++) cost_mem[a] = 7'($urandom_range(0, 127));
        RST   = 1'b0;
        req   = '0;
        req_w = '0;
        req_j = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_drv[k] = 0;
            j_drv[k] = 0;
        end
        modelReset();
        @(negedge CLK);
        #1;
        checkResetZero("por");
        RST = 1'b1;

        $display("[TB] single request from engine 0");
        applyStimulus(2'b01);
        repeat (10) applyStimulus(2'b00);

        $display("[TB] simultaneous requests after reset");
        doReset();
        repeat (8) applyStimulus(2'b11);
        repeat (8) applyStimulus(2'b10);
        repeat (4) applyStimulus(2'b00);

        $display("[TB] continuous requests");
        repeat (48) applyStimulus(2'b11);
        repeat (10) applyStimulus(2'b00);

        $display("[TB] engine 1 drops request mid-burst");
        repeat (5) applyStimulus(2'b10);
        repeat (12) applyStimulus(2'b00);

        $display("[TB] reset during an engine 0 burst");
        repeat (5) applyStimulus(2'b01);
        doReset();
        repeat (12) applyStimulus(2'b01);
        repeat (10) applyStimulus(2'b00);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                applyStimulus(2'($urandom_range(0, 3)));
            end
        end
        repeat (BURST + 4) applyStimulus(2'b00);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
